// File: rtl/ahb_slave_mux_slave_2_pkg.sv
// Shared AHB types for the slave_2 downstream mux.
// Latency: n/a (types only); backpressure: n/a.
package ahb_slave_mux_slave_2_pkg;

  localparam int HSIZE_W = 3;

  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_type;
  typedef enum logic [1:0] {OKAY, ERROR, RETRY, SPLIT} hresp_type;
  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } hburst_type;

  function automatic logic is_active(htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_mux_slave_2_if.sv
// Bus bundle between the slave_2 arbiter/masters and slave_2 itself.
// Latency: n/a (wires only); backpressure: carried by s_hreadyout / m_hready.
interface ahb_slave_mux_slave_2_if
  import ahb_slave_mux_slave_2_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [MASTER_NUM-1:0] hgrant;
  logic [ADDR_W-1:0]     m_haddr  [MASTER_NUM];
  htrans_type            m_htrans [MASTER_NUM];
  logic [MASTER_NUM-1:0] m_hwrite;
  logic [HSIZE_W-1:0]    m_hsize  [MASTER_NUM];
  hburst_type            m_hburst [MASTER_NUM];
  logic [DATA_W-1:0]     m_hwdata [MASTER_NUM];

  logic [ADDR_W-1:0]     s_haddr;
  htrans_type            s_htrans;
  logic                  s_hwrite;
  logic [HSIZE_W-1:0]    s_hsize;
  hburst_type            s_hburst;
  logic                  s_hsel;
  logic [DATA_W-1:0]     s_hwdata;
  logic [DATA_W-1:0]     s_hrdata;
  logic                  s_hreadyout;
  hresp_type             s_hresp;

  logic [DATA_W-1:0]     m_hrdata;
  logic [MASTER_NUM-1:0] m_hready;
  hresp_type             m_hresp  [MASTER_NUM];
  logic                  hwait;
  logic                  grant_err;

  modport slave (
    input  hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  s_hrdata, s_hreadyout, s_hresp,
    output s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hsel, s_hwdata,
    output m_hrdata, m_hready, m_hresp, hwait, grant_err
  );

  modport master (
    output hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output s_hrdata, s_hreadyout, s_hresp,
    input  s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hsel, s_hwdata,
    input  m_hrdata, m_hready, m_hresp, hwait, grant_err
  );

endinterface

// File: rtl/ahb_slave_mux_slave_2_onehot_mux.sv
// One-hot select; overlapping selects resolve to the lowest index, no select gives 0.
// Latency: combinational; backpressure: none.
module ahb_onehot_mux #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) dout = din[i];
    end
  end

endmodule

// File: rtl/ahb_slave_mux_slave_2.sv
// Routes the owning master to slave_2 and returns ready/resp; ownership survives hgrant dropping in wait states.
// Latency: address path combinational, data phase one accepted cycle later; backpressure: s_hreadyout freezes both phases.
module ahb_slave_mux_slave_2
  import ahb_slave_mux_slave_2_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input logic              hclk,
  input logic              hreset_n,
  ahb_slave_mux_slave_2_if.slave bus
);

  localparam int BW = ADDR_W + 2 + 1 + HSIZE_W + 3;

  logic [MASTER_NUM-1:0] addr_own_q, addr_own_d;
  logic [MASTER_NUM-1:0] data_own_q, data_own_d;
  logic                  data_act_q, data_act_d;
  logic                  grant_err_q, grant_err_d;
  logic [MASTER_NUM-1:0] addr_sel;

  logic [MASTER_NUM-1:0][BW-1:0]     addr_din;
  logic [MASTER_NUM-1:0][DATA_W-1:0] wdata_din;
  logic [BW-1:0]                     addr_dout;
  logic [1:0]                        sel_trans;
  logic [2:0]                        sel_burst;

  // Reset also masks the live grant so outputs read idle while hreset_n is low.
  always_comb begin
    addr_sel = '0;
    if (hreset_n) addr_sel = bus.s_hreadyout ? bus.hgrant : addr_own_q;
  end

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      addr_din[i]  = {bus.m_haddr[i], bus.m_htrans[i], bus.m_hwrite[i],
                      bus.m_hsize[i], bus.m_hburst[i]};
      wdata_din[i] = bus.m_hwdata[i];
    end
  end

  ahb_onehot_mux #(.N(MASTER_NUM), .W(BW)) u_addr_mux (
    .sel  (addr_sel),
    .din  (addr_din),
    .dout (addr_dout)
  );

  ahb_onehot_mux #(.N(MASTER_NUM), .W(DATA_W)) u_wdata_mux (
    .sel  (data_own_q),
    .din  (wdata_din),
    .dout (bus.s_hwdata)
  );

  assign {bus.s_haddr, sel_trans, bus.s_hwrite, bus.s_hsize, sel_burst} = addr_dout;
  assign bus.s_htrans  = htrans_type'(sel_trans);
  assign bus.s_hburst  = hburst_type'(sel_burst);
  assign bus.s_hsel    = |addr_sel;
  assign bus.m_hrdata  = bus.s_hrdata;
  assign bus.hwait     = ~bus.s_hreadyout;
  assign bus.grant_err = grant_err_q;

  always_comb begin
    addr_own_d  = addr_sel;
    data_own_d  = data_own_q;
    data_act_d  = data_act_q;
    grant_err_d = grant_err_q | ($countones(bus.hgrant) > 1);
    if (bus.s_hreadyout) begin
      data_own_d = addr_sel;
      data_act_d = bus.s_hsel && is_active(bus.s_htrans);
    end
  end

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      bus.m_hready[i] = 1'b1;
      bus.m_hresp[i]  = OKAY;
      if (data_own_q[i] && data_act_q) begin
        bus.m_hready[i] = bus.s_hreadyout;
        bus.m_hresp[i]  = bus.s_hresp;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      addr_own_q  <= '0;
      data_own_q  <= '0;
      data_act_q  <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      addr_own_q  <= addr_own_d;
      data_own_q  <= data_own_d;
      data_act_q  <= data_act_d;
      grant_err_q <= grant_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mux_slave_2.sv
// Directed stimulus for ahb_slave_mux_slave_2; expectations are queued per cycle
// and a negedge monitor pops and compares them against the DUT.
module tb_ahb_slave_mux_slave_2;
  import ahb_slave_mux_slave_2_pkg::*;

  logic hclk;
  logic hreset_n;
  int   checks = 0;
  int   errors = 0;

  ahb_slave_mux_slave_2_if #(.MASTER_NUM(2), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb_slave_mux_slave_2 #(.MASTER_NUM(2), .ADDR_W(32), .DATA_W(32)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [6:0]  chk;  // 0 addr, 1 wdata, 2 ready/hwait, 3 resp, 5 grant_err, 6 rdata
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic [1:0]  hready;
    logic        hwait;
    logic [1:0]  resp0;
    logic [1:0]  resp1;
    logic        gerr;
  } exp_t;

  exp_t  exq[$];
  string nmq[$];
  exp_t  e;
  exp_t  mx;
  string mn;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (exq.size() > 0) begin
      mx = exq.pop_front();
      mn = nmq.pop_front();
      if (mx.chk[0]) begin
        cmp({mn, ".s_hsel"},   bus.s_hsel,   mx.hsel);
        cmp({mn, ".s_htrans"}, bus.s_htrans, mx.htrans);
        cmp({mn, ".s_haddr"},  bus.s_haddr,  mx.haddr);
        cmp({mn, ".s_hwrite"}, bus.s_hwrite, mx.hwrite);
        cmp({mn, ".s_hsize"},  bus.s_hsize,  mx.hsize);
        cmp({mn, ".s_hburst"}, bus.s_hburst, mx.hburst);
      end
      if (mx.chk[1]) cmp({mn, ".s_hwdata"}, bus.s_hwdata, mx.hwdata);
      if (mx.chk[2]) begin
        cmp({mn, ".m_hready"}, bus.m_hready, mx.hready);
        cmp({mn, ".hwait"},    bus.hwait,    mx.hwait);
      end
      if (mx.chk[3]) begin
        cmp({mn, ".m_hresp0"}, bus.m_hresp[0], mx.resp0);
        cmp({mn, ".m_hresp1"}, bus.m_hresp[1], mx.resp1);
      end
      if (mx.chk[5]) cmp({mn, ".grant_err"}, bus.grant_err, mx.gerr);
      if (mx.chk[6]) cmp({mn, ".m_hrdata"},  bus.m_hrdata,  mx.hrdata);
    end
  end

  task automatic next_cycle();
    @(posedge hclk);
    #1;
    e = '0;
  endtask

  task automatic set_m(int i, htrans_type t, logic [31:0] a, logic w, hburst_type b);
    bus.m_htrans[i] = t;
    bus.m_haddr[i]  = a;
    bus.m_hwrite[i] = w;
    bus.m_hsize[i]  = 3'd2;
    bus.m_hburst[i] = b;
  endtask

  task automatic ex_addr(logic sel, htrans_type t, logic [31:0] a, logic w, logic [2:0] sz, hburst_type b);
    e.chk[0] = 1'b1; e.hsel = sel; e.htrans = t; e.haddr = a;
    e.hwrite = w; e.hsize = sz; e.hburst = b;
  endtask

  task automatic ex_idle();
    ex_addr(1'b0, IDLE, 32'h0, 1'b0, 3'd0, SINGLE);
  endtask

  task automatic ex_wd(logic [31:0] d);
    e.chk[1] = 1'b1; e.hwdata = d;
  endtask

  task automatic ex_rdy(logic [1:0] r, logic w);
    e.chk[2] = 1'b1; e.hready = r; e.hwait = w;
  endtask

  task automatic ex_resp(hresp_type r0, hresp_type r1);
    e.chk[3] = 1'b1; e.resp0 = r0; e.resp1 = r1;
  endtask

  task automatic ex_gerr(logic g);
    e.chk[5] = 1'b1; e.gerr = g;
  endtask

  task automatic ex_rd(logic [31:0] d);
    e.chk[6] = 1'b1; e.hrdata = d;
  endtask

  task automatic push(string n);
    exq.push_back(e);
    nmq.push_back(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset_n        = 1'b0;
    bus.hgrant      = 2'b00;
    bus.s_hreadyout = 1'b1;
    bus.s_hresp     = OKAY;
    bus.s_hrdata    = 32'h0;
    for (int i = 0; i < 2; i++) begin
      set_m(i, IDLE, 32'h0, 1'b0, SINGLE);
      bus.m_hwdata[i] = 32'h0;
    end

    // Reset state
    next_cycle();
    ex_idle(); ex_rdy(2'b11, 1'b0); ex_resp(OKAY, OKAY); ex_gerr(1'b0);
    push("rst");
    @(negedge hclk); #1;
    hreset_n = 1'b1;

    // Single write by m0, data phase waits one cycle
    next_cycle();
    bus.hgrant = 2'b01; set_m(0, NONSEQ, 32'h100, 1'b1, SINGLE);
    ex_addr(1'b1, NONSEQ, 32'h100, 1'b1, 3'd2, SINGLE); ex_rdy(2'b11, 1'b0);
    push("t2_addr");
    next_cycle();
    bus.hgrant = 2'b00; set_m(0, IDLE, 32'h100, 1'b1, SINGLE);
    bus.m_hwdata[0] = 32'hAAAA_0001; bus.s_hreadyout = 1'b0;
    ex_wd(32'hAAAA_0001); ex_rdy(2'b10, 1'b1);
    push("t2_data_wait");
    next_cycle();
    bus.s_hreadyout = 1'b1;
    ex_idle(); ex_wd(32'hAAAA_0001); ex_rdy(2'b11, 1'b0);
    push("t2_data_done");

    // m1 read with three wait states
    next_cycle();
    bus.hgrant = 2'b10; set_m(0, IDLE, 32'h0, 1'b0, SINGLE);
    set_m(1, NONSEQ, 32'h200, 1'b0, SINGLE);
    ex_addr(1'b1, NONSEQ, 32'h200, 1'b0, 3'd2, SINGLE); ex_wd(32'h0); ex_rdy(2'b11, 1'b0);
    push("t3_addr");
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus.hgrant = 2'b00; set_m(1, IDLE, 32'h200, 1'b0, SINGLE); bus.s_hreadyout = 1'b0;
      ex_addr(1'b1, IDLE, 32'h200, 1'b0, 3'd2, SINGLE); ex_rdy(2'b01, 1'b1);
      push("t3_wait");
    end
    next_cycle();
    bus.s_hreadyout = 1'b1; bus.s_hrdata = 32'h5555_1234;
    ex_idle(); ex_rdy(2'b11, 1'b0); ex_rd(32'h5555_1234);
    push("t3_done");

    // INCR4 by m0, handover to m1 on the last beat's data phase
    next_cycle();
    bus.hgrant = 2'b01; set_m(1, IDLE, 32'h0, 1'b0, SINGLE);
    set_m(0, NONSEQ, 32'h300, 1'b1, INCR4);
    ex_addr(1'b1, NONSEQ, 32'h300, 1'b1, 3'd2, INCR4); ex_rdy(2'b11, 1'b0);
    push("t4_beat0");
    for (int b = 1; b < 4; b++) begin
      next_cycle();
      set_m(0, SEQ, 32'h300 + 32'(4 * b), 1'b1, INCR4);
      bus.m_hwdata[0] = 32'hD000_0000 + 32'(b - 1);
      ex_addr(1'b1, SEQ, 32'h300 + 32'(4 * b), 1'b1, 3'd2, INCR4);
      ex_wd(32'hD000_0000 + 32'(b - 1)); ex_rdy(2'b11, 1'b0);
      push("t4_beat");
    end
    next_cycle();
    bus.hgrant = 2'b10; set_m(0, IDLE, 32'h0, 1'b0, SINGLE);
    bus.m_hwdata[0] = 32'hD000_0003; set_m(1, NONSEQ, 32'h400, 1'b1, SINGLE);
    ex_addr(1'b1, NONSEQ, 32'h400, 1'b1, 3'd2, SINGLE); ex_wd(32'hD000_0003);
    ex_rdy(2'b11, 1'b0);
    push("t4_handover");
    next_cycle();
    bus.hgrant = 2'b00; set_m(1, IDLE, 32'h0, 1'b0, SINGLE); bus.m_hwdata[1] = 32'hE000_0000;
    ex_idle(); ex_wd(32'hE000_0000);
    push("t4_m1_data");

    // Two-cycle ERROR response to m1
    next_cycle();
    bus.hgrant = 2'b10; set_m(1, NONSEQ, 32'h500, 1'b0, SINGLE);
    ex_addr(1'b1, NONSEQ, 32'h500, 1'b0, 3'd2, SINGLE); ex_wd(32'h0);
    push("t5_addr");
    next_cycle();
    bus.hgrant = 2'b00; set_m(1, IDLE, 32'h500, 1'b0, SINGLE);
    bus.s_hreadyout = 1'b0; bus.s_hresp = ERROR;
    ex_rdy(2'b01, 1'b1); ex_resp(OKAY, ERROR);
    push("t5_err1");
    next_cycle();
    bus.s_hreadyout = 1'b1;
    ex_idle(); ex_rdy(2'b11, 1'b0); ex_resp(OKAY, ERROR);
    push("t5_err2");
    next_cycle();
    bus.s_hresp = OKAY;
    ex_resp(OKAY, OKAY);
    push("t5_after");

    // Overlapping grant, then reset mid-burst
    next_cycle();
    bus.hgrant = 2'b11; set_m(0, NONSEQ, 32'h600, 1'b1, INCR);
    set_m(1, NONSEQ, 32'h700, 1'b0, SINGLE);
    ex_addr(1'b1, NONSEQ, 32'h600, 1'b1, 3'd2, INCR); ex_gerr(1'b0);
    push("t6_dual");
    next_cycle();
    bus.hgrant = 2'b01; set_m(0, SEQ, 32'h604, 1'b1, INCR); set_m(1, IDLE, 32'h0, 1'b0, SINGLE);
    ex_addr(1'b1, SEQ, 32'h604, 1'b1, 3'd2, INCR); ex_gerr(1'b1);
    push("t6_sticky");
    next_cycle();
    bus.hgrant = 2'b00; set_m(0, SEQ, 32'h608, 1'b1, INCR); bus.s_hreadyout = 1'b0;
    ex_addr(1'b1, SEQ, 32'h608, 1'b1, 3'd2, INCR); ex_rdy(2'b10, 1'b1); ex_gerr(1'b1);
    push("t6_wait");
    next_cycle();
    hreset_n = 1'b0;
    ex_idle(); ex_rdy(2'b11, 1'b1); ex_gerr(1'b0); ex_wd(32'h0);
    push("t6_in_reset");
    @(negedge hclk); #1;
    hreset_n = 1'b1;
    next_cycle();
    ex_idle(); ex_rdy(2'b11, 1'b1); ex_gerr(1'b0); ex_wd(32'h0);
    push("t6_post_reset");
    next_cycle();
    bus.s_hreadyout = 1'b1; set_m(0, IDLE, 32'h0, 1'b0, SINGLE);

    for (int k = 0; k < 5 && exq.size() > 0; k++) @(negedge hclk);
    #1;
    if (exq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
